// File: rtl/order_risk_pkg.sv
// rtl/order_risk_pkg.sv - shared state type and default widths for the order risk engine
package order_risk_pkg;

    localparam int QTY_W_DEF      = 16;
    localparam int PRICE_W_DEF    = 16;
    localparam int NOTIONAL_W_DEF = QTY_W_DEF + PRICE_W_DEF;
    localparam int EXPO_W_DEF     = 40;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        CMP,
        PASS,
        WMAX,
        WORD
    } ore_state_t;

endpackage

// File: rtl/order_fifo.sv
// rtl/order_fifo.sv - power-of-two output FIFO carrying accepted orders to the gateway
module order_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    input  logic              m_tready,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;

    assign pop   = !empty && m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push  = s_tvalid && (!full || pop);
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_tdata;
    end

    assign m_tdata = mem[rd_ptr];

endmodule

// File: rtl/order_risk_engine.sv
// rtl/order_risk_engine.sv - notional/exposure risk check and order commit datapath behind the order FSM
module order_risk_engine
    import order_risk_pkg::*;
#(
    parameter int                     QTY_W      = QTY_W_DEF,
    parameter int                     PRICE_W    = PRICE_W_DEF,
    parameter int                     NOTIONAL_W = NOTIONAL_W_DEF,
    parameter int                     EXPO_W     = EXPO_W_DEF,
    parameter logic [EXPO_W:0]        EXPO_LIMIT = (EXPO_W+1)'(1) << 39,
    parameter logic [NOTIONAL_W-1:0]  MAX_RST    = '0,
    parameter int                     FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  check_risk,
    input  logic                  send_order,
    input  logic                  update_max,
    input  logic [QTY_W-1:0]      order_qty,
    input  logic [PRICE_W-1:0]    order_price,
    input  logic [NOTIONAL_W-1:0] max_in,
    input  logic                  clear_exposure,
    output logic                  risk_ok,
    output logic                  risk_fail,
    output logic                  memwr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QTY_W-1:0]      out_qty,
    output logic [PRICE_W-1:0]    out_price,
    output logic [EXPO_W-1:0]     exposure,
    output logic                  fifo_full
);

    localparam int FIFO_W = QTY_W + PRICE_W;

    ore_state_t            state;
    ore_state_t            state_next;
    logic                  chk_q;
    logic                  send_q;
    logic                  upd_q;
    logic                  chk_rise;
    logic                  send_rise;
    logic                  upd_rise;
    logic                  pend_chk;
    logic                  pend_max;
    logic                  latch_ord;
    logic                  fail_q;
    logic                  pass_now;
    logic [QTY_W-1:0]      qty_r;
    logic [PRICE_W-1:0]    price_r;
    logic [NOTIONAL_W-1:0] notional;
    logic [NOTIONAL_W-1:0] max_reg;
    logic [EXPO_W:0]       notional_x;
    logic [EXPO_W:0]       expo_sum;
    logic [EXPO_W:0]       word_sum;
    logic [FIFO_W-1:0]     fifo_head;
    logic                  fifo_empty;

    assign chk_rise  = check_risk && !chk_q;
    assign send_rise = send_order && !send_q;
    assign upd_rise  = update_max && !upd_q;

    // One guard bit so the limit compare and the saturating add never wrap
    assign notional_x = (EXPO_W+1)'(notional);
    assign expo_sum   = {1'b0, exposure} + notional_x;
    assign word_sum   = (clear_exposure ? '0 : {1'b0, exposure}) + notional_x;
    assign pass_now   = (notional <= max_reg) && (expo_sum <= EXPO_LIMIT) && !fifo_full;

    always_comb begin
        state_next = state;
        latch_ord  = 1'b0;
        case (state)
            IDLE: begin
                latch_ord = chk_rise;
                if (upd_rise || pend_max)      state_next = WMAX;
                else if (chk_rise || pend_chk) state_next = MUL;
            end
            MUL:  state_next = CMP;
            CMP:  state_next = pass_now ? PASS : IDLE;
            PASS: begin
                if (send_rise)        state_next = WORD;
                else if (!check_risk) state_next = IDLE;
            end
            WMAX:    state_next = IDLE;
            WORD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            chk_q     <= 1'b0;
            send_q    <= 1'b0;
            upd_q     <= 1'b0;
            pend_chk  <= 1'b0;
            pend_max  <= 1'b0;
            qty_r     <= '0;
            price_r   <= '0;
            notional  <= '0;
            max_reg   <= MAX_RST;
            exposure  <= '0;
            risk_ok   <= 1'b0;
            fail_q    <= 1'b0;
            risk_fail <= 1'b0;
            memwr     <= 1'b0;
        end else begin
            state  <= state_next;
            chk_q  <= check_risk;
            send_q <= send_order;
            upd_q  <= update_max;

            if (latch_ord) begin
                qty_r   <= order_qty;
                price_r <= order_price;
            end

            // A max update arriving mid-check waits; a check colliding with one waits behind it
            if (state == IDLE && state_next == WMAX) pend_max <= 1'b0;
            else if (upd_rise && state != IDLE)      pend_max <= 1'b1;
            if (state == IDLE) pend_chk <= (state_next == WMAX) && (chk_rise || pend_chk);

            if (state == MUL)  notional <= NOTIONAL_W'(qty_r) * NOTIONAL_W'(price_r);
            if (state == WMAX) max_reg  <= max_in;

            if (state == WORD)       exposure <= word_sum[EXPO_W] ? '1 : word_sum[EXPO_W-1:0];
            else if (clear_exposure) exposure <= '0;

            risk_ok   <= (state == PASS) && (state_next == PASS);
            fail_q    <= (state == CMP) && !pass_now;
            risk_fail <= fail_q;
            memwr     <= (state == WORD) || (state == WMAX);
        end
    end

    order_fifo #(
        .DATA_W (FIFO_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  ({qty_r, price_r}),
        .s_tvalid (state == WORD),
        .m_tdata  (fifo_head),
        .m_tready (out_ready),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_qty   = fifo_head[FIFO_W-1 -: QTY_W];
    assign out_price = fifo_head[PRICE_W-1:0];

endmodule

// File: tb/tb_order_risk_engine.sv
// tb/tb_order_risk_engine.sv - directed self-checking bench for order_risk_engine
module tb_order_risk_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        check_risk;
    logic        send_order;
    logic        update_max;
    logic [15:0] order_qty;
    logic [15:0] order_price;
    logic [31:0] max_in;
    logic        clear_exposure;
    logic        risk_ok;
    logic        risk_fail;
    logic        memwr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_qty;
    logic [15:0] out_price;
    logic [39:0] exposure;
    logic        fifo_full;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q [$];
    logic [15:0] last_qty;
    logic [15:0] last_price;

    always #5 clk = ~clk;

    order_risk_engine #(
        .EXPO_LIMIT (41'd1200),
        .MAX_RST    (32'd100)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .check_risk     (check_risk),
        .send_order     (send_order),
        .update_max     (update_max),
        .order_qty      (order_qty),
        .order_price    (order_price),
        .max_in         (max_in),
        .clear_exposure (clear_exposure),
        .risk_ok        (risk_ok),
        .risk_fail      (risk_fail),
        .memwr          (memwr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_qty        (out_qty),
        .out_price      (out_price),
        .exposure       (exposure),
        .fifo_full      (fifo_full)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_check(input logic [15:0] q, input logic [15:0] p, input logic pass, input string tag);
        order_qty   = q;
        order_price = p;
        last_qty    = q;
        last_price  = p;
        check_risk  = 1'b1;
        step(3);
        check({tag, " latency"}, {risk_ok, risk_fail}, 2'b00);
        step(1);
        check({tag, " verdict"}, {risk_ok, risk_fail}, {pass, !pass});
        if (!pass) begin
            check_risk = 1'b0;
            step(1);
            check({tag, " fail pulse"}, risk_fail, 1'b0);
        end
    endtask

    task automatic do_send(input logic clr, input string tag);
        send_order = 1'b1;
        exp_q.push_back({last_qty, last_price});
        step(1);
        clear_exposure = clr;
        step(1);
        check({tag, " memwr"}, memwr, 1'b1);
        check({tag, " out_valid"}, out_valid, 1'b1);
        send_order     = 1'b0;
        check_risk     = 1'b0;
        clear_exposure = 1'b0;
        step(1);
        check({tag, " memwr pulse"}, memwr, 1'b0);
    endtask

    task automatic discard(input string tag);
        check_risk = 1'b0;
        step(2);
        check({tag, " risk_ok drop"}, risk_ok, 1'b0);
        check({tag, " no write"}, memwr, 1'b0);
    endtask

    task automatic do_max(input logic [31:0] v, input string tag);
        update_max = 1'b1;
        max_in     = v;
        step(2);
        check({tag, " memwr"}, memwr, 1'b1);
        update_max = 1'b0;
        step(1);
        check({tag, " memwr pulse"}, memwr, 1'b0);
    endtask

    task automatic pop_one(input string tag);
        logic [31:0] exp_v;
        check({tag, " valid"}, out_valid, 1'b1);
        check({tag, " scoreboard"}, exp_q.size() != 0, 1'b1);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check({tag, " head"}, {out_qty, out_price}, exp_v);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_exposure = 1'b1;
        step(1);
        clear_exposure = 1'b0;
        check("clear exposure", exposure, 40'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        check_risk     = 1'b0;
        send_order     = 1'b0;
        update_max     = 1'b0;
        order_qty      = '0;
        order_price    = '0;
        max_in         = '0;
        clear_exposure = 1'b0;
        out_ready      = 1'b0;
        last_qty       = '0;
        last_price     = '0;
        step(3);
        check("rst risk_ok", risk_ok, 1'b0);
        check("rst risk_fail", risk_fail, 1'b0);
        check("rst memwr", memwr, 1'b0);
        check("rst out_valid", out_valid, 1'b0);
        check("rst fifo_full", fifo_full, 1'b0);
        check("rst exposure", exposure, 40'd0);
        rst_n = 1'b1;
        step(2);

        // Reset maximum of 100: equal passes, one above fails
        do_check(16'd10, 16'd10, 1'b1, "at max_rst");
        discard("discard");
        check("discard fifo", out_valid, 1'b0);
        do_check(16'd101, 16'd1, 1'b0, "over max_rst");

        do_max(32'd1000, "max1000");
        do_check(16'd10, 16'd50, 1'b1, "order500");
        do_send(1'b0, "send500");
        check("expo 500", exposure, 40'd500);
        pop_one("pop 10x50");

        do_check(16'd40, 16'd50, 1'b0, "order2000");
        check("order2000 fifo", out_valid, 1'b0);
        check("order2000 expo", exposure, 40'd500);

        // Cumulative limit of 1200
        do_check(16'd10, 16'd50, 1'b1, "expo2");
        do_send(1'b0, "expo2 send");
        check("expo 1000", exposure, 40'd1000);
        do_check(16'd10, 16'd50, 1'b0, "expo3 over");
        pulse_clear();
        do_check(16'd10, 16'd50, 1'b1, "retry");
        do_send(1'b0, "retry send");
        check("expo retry", exposure, 40'd500);
        do_check(16'd14, 16'd50, 1'b1, "at limit");
        do_send(1'b0, "at limit send");
        check("expo 1200", exposure, 40'd1200);
        do_check(16'd1, 16'd1, 1'b0, "limit+1");
        pulse_clear();
        do_check(16'd3, 16'd100, 1'b1, "order300");
        do_send(1'b0, "order300 send");
        do_check(16'd2, 16'd50, 1'b1, "order100");
        do_send(1'b1, "clear with word");
        check("clear then add", exposure, 40'd100);
        while (exp_q.size() != 0) pop_one("drain1");
        check("drain1 empty", out_valid, 1'b0);

        // Fill the FIFO with the gateway stalled
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            do_check(16'(i + 1), 16'd2, 1'b1, "fill");
            do_send(1'b0, "fill send");
        end
        check("fill full", fifo_full, 1'b1);
        do_check(16'd1, 16'd1, 1'b0, "full reject");
        pop_one("pop on full");
        check("after pop full", fifo_full, 1'b0);
        do_check(16'd9, 16'd2, 1'b1, "refill");
        do_send(1'b0, "refill send");
        check("refill full", fifo_full, 1'b1);
        check("fill expo", exposure, 40'd90);
        while (exp_q.size() != 0) pop_one("drain2");
        check("drain2 empty", out_valid, 1'b0);
        check("drain2 full", fifo_full, 1'b0);

        // Same-cycle max update and check: write first, then check against new max
        order_qty   = 16'd22;
        order_price = 16'd50;
        max_in      = 32'd3000;
        update_max  = 1'b1;
        check_risk  = 1'b1;
        step(2);
        check("collide memwr", memwr, 1'b1);
        update_max = 1'b0;
        step(4);
        check("collide verdict", {risk_ok, risk_fail}, 2'b10);
        discard("collide discard");

        // Reset while holding PASS with a non-empty FIFO
        do_check(16'd1, 16'd1, 1'b1, "pre reset");
        do_send(1'b0, "pre reset send");
        do_check(16'd10, 16'd10, 1'b1, "in pass");
        rst_n = 1'b0;
        #1;
        check("mid rst risk_ok", risk_ok, 1'b0);
        check("mid rst out_valid", out_valid, 1'b0);
        check("mid rst exposure", exposure, 40'd0);
        check("mid rst memwr", memwr, 1'b0);
        check_risk = 1'b0;
        exp_q.delete();
        step(1);
        rst_n = 1'b1;
        step(1);
        do_check(16'd101, 16'd1, 1'b0, "post rst over max");
        do_check(16'd100, 16'd1, 1'b1, "post rst at max");
        discard("post rst discard");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
